clock_mode_ctrl: RTL and testbench

Mode sequencer and timekeeper for the digital clock, sitting directly downstream of the frequency divider in the `clkM` domain. It edge-detects the divider's 1 s square wave (`sec_sq`) and slow set-mode square wave (`set_sq`), keeps the hours/minutes/seconds registers, and runs the RUN → SET_HR → SET_MIN state machine. In the set states it drives increment, auto-repeat, blink and inactivity-timeout behaviour from two debounced push-buttons.

---
 rtl/clock_mode_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer and timekeeper for the digital clock: edge-detects the divider
// square waves and buttons, keeps h/m/s and runs the RUN -> SET_HR -> SET_MIN FSM.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_S  = 30,
  parameter int unsigned REPEAT_DLY = 2
) (
  input  logic       clkM,
  input  logic       clr,
  input  logic       sec_sq,
  input  logic       set_sq,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink_hr,
  output logic       blink_min,
  output logic       sec_tick
);

  localparam int unsigned IDLE_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam int unsigned RPT_W  = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t state, state_n;

  logic sec_r, sec_p, set_r, set_p, mode_r, mode_p, inc_r, inc_p;
  logic sec_rise, set_rise, mode_rise, inc_rise;

  logic [4:0]        hours_n;
  logic [5:0]        minutes_n, seconds_n;
  logic [IDLE_W-1:0] idle, idle_n;
  logic [RPT_W-1:0]  rpt, rpt_n;
  logic              rpt_fire;
  logic              tick_n, blink_hr_n, blink_min_n;

  // Inputs are registered once, then compared with their previous sample;
  // during clr both stages load the live level so a held input gives no edge.
  always_ff @(posedge clkM) begin
    if (clr) begin
      sec_r  <= sec_sq;   sec_p  <= sec_sq;
      set_r  <= set_sq;   set_p  <= set_sq;
      mode_r <= btn_mode; mode_p <= btn_mode;
      inc_r  <= btn_inc;  inc_p  <= btn_inc;
    end else begin
      sec_r  <= sec_sq;   sec_p  <= sec_r;
      set_r  <= set_sq;   set_p  <= set_r;
      mode_r <= btn_mode; mode_p <= mode_r;
      inc_r  <= btn_inc;  inc_p  <= inc_r;
    end
  end

  assign sec_rise  = sec_r  & ~sec_p;
  assign set_rise  = set_r  & ~set_p;
  assign mode_rise = mode_r & ~mode_p;
  assign inc_rise  = inc_r  & ~inc_p;

  // State register and timekeeping registers.
  always_ff @(posedge clkM) begin
    if (clr) begin
      state     <= RUN;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      idle      <= '0;
      rpt       <= '0;
      sec_tick  <= 1'b0;
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      state     <= state_n;
      hours     <= hours_n;
      minutes   <= minutes_n;
      seconds   <= seconds_n;
      idle      <= idle_n;
      rpt       <= rpt_n;
      sec_tick  <= tick_n;
      blink_hr  <= blink_hr_n;
      blink_min <= blink_min_n;
    end
  end

  assign mode = state;

  // Next-state and datapath; mode rise outranks increments and timeout.
  always_comb begin
    state_n     = state;
    hours_n     = hours;
    minutes_n   = minutes;
    seconds_n   = seconds;
    idle_n      = idle;
    rpt_n       = rpt;
    rpt_fire    = 1'b0;
    tick_n      = 1'b0;
    blink_hr_n  = (state == SET_HR) && set_r;
    blink_min_n = (state == SET_MIN) && set_r;

    case (state)
      RUN: begin
        idle_n = '0;
        rpt_n  = '0;
        if (mode_rise) begin
          state_n   = SET_HR;
          seconds_n = '0;
        end else if (sec_rise) begin
          tick_n = 1'b1;
          if (seconds == 6'd59) begin
            seconds_n = '0;
            if (minutes == 6'd59) begin
              minutes_n = '0;
              hours_n   = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end else begin
              minutes_n = minutes + 6'd1;
            end
          end else begin
            seconds_n = seconds + 6'd1;
          end
        end
      end

      SET_HR, SET_MIN: begin
        seconds_n = '0;
        // Auto-repeat counter saturates at REPEAT_DLY, then each set_sq rise fires.
        if (!inc_r) begin
          rpt_n = '0;
        end else if (set_rise) begin
          if (rpt == RPT_W'(REPEAT_DLY)) rpt_fire = 1'b1;
          else                           rpt_n    = rpt + 1'b1;
        end

        if (mode_rise) begin
          state_n = (state == SET_HR) ? SET_MIN : RUN;
          idle_n  = '0;
          rpt_n   = '0;
        end else if (inc_rise || rpt_fire) begin
          idle_n = '0;
          if (state == SET_HR) hours_n   = (hours == 5'd23)   ? 5'd0 : hours + 5'd1;
          else                 minutes_n = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end else if (idle == IDLE_W'(TIMEOUT_S)) begin
          state_n = RUN;
          idle_n  = '0;
          rpt_n   = '0;
        end else if (sec_rise) begin
          idle_n = idle + 1'b1;
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl: counting, setting,
// auto-repeat, timeout, blink, collisions and reset behaviour.
module tb_clock_mode_ctrl;

  logic       clkM = 1'b0;
  logic       clr, sec_sq, set_sq, btn_mode, btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] mode;
  logic       blink_hr, blink_min, sec_tick;

  int tests  = 0;
  int failed = 0;
  int tick_hi = 0;
  int tick_rises = 0;
  bit tick_last = 1'b0;

  clock_mode_ctrl #(.TIMEOUT_S(30), .REPEAT_DLY(2)) dut (
    .clkM(clkM), .clr(clr), .sec_sq(sec_sq), .set_sq(set_sq),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours(hours), .minutes(minutes), .seconds(seconds), .mode(mode),
    .blink_hr(blink_hr), .blink_min(blink_min), .sec_tick(sec_tick)
  );

  always #5 clkM = ~clkM;

  // sec_tick monitor: total high cycles and number of separate pulses.
  always @(negedge clkM) begin
    if (sec_tick === 1'b1) begin
      tick_hi++;
      if (!tick_last) tick_rises++;
    end
    tick_last = (sec_tick === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clkM);
    #1;
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      sec_sq = 1'b1; cyc(2); sec_sq = 1'b0; cyc(2);
    end
  endtask

  task automatic pulse_set(input int n);
    for (int i = 0; i < n; i++) begin
      set_sq = 1'b1; cyc(2); set_sq = 1'b0; cyc(2);
    end
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; cyc(2); btn_inc = 1'b0; cyc(2);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(2); btn_mode = 1'b0; cyc(2);
  endtask

  task automatic test_reset();
    clr = 1'b1; sec_sq = 1'b1; set_sq = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(2);
    tests++;
    if ({hours, minutes, seconds, mode, blink_hr, blink_min, sec_tick} !== 26'd0) begin
      failed++;
      $display("FAIL reset_state: got h=%0d m=%0d s=%0d mode=%0d bh=%b bm=%b tick=%b, expected all 0",
               hours, minutes, seconds, mode, blink_hr, blink_min, sec_tick);
    end
    clr = 1'b0;
    cyc(4);
    tests++;
    if (seconds !== 6'd0 || tick_hi != 0) begin
      failed++;
      $display("FAIL reset_no_edge: got s=%0d ticks=%0d, expected 0 0", seconds, tick_hi);
    end
    sec_sq = 1'b0;
    cyc(2);
  endtask

  task automatic test_run_count();
    int hi0, ri0;
    hi0 = tick_hi; ri0 = tick_rises;
    pulse_sec(60);
    tests++;
    if (hours !== 5'd0 || minutes !== 6'd1 || seconds !== 6'd0) begin
      failed++;
      $display("FAIL run_count: got %0d:%0d:%0d, expected 0:1:0", hours, minutes, seconds);
    end
    tests++;
    if (tick_hi - hi0 != 60 || tick_rises - ri0 != 60) begin
      failed++;
      $display("FAIL sec_tick_pulses: got high=%0d pulses=%0d, expected 60 60",
               tick_hi - hi0, tick_rises - ri0);
    end
  endtask

  task automatic test_set_nocarry();
    press_mode();
    tests++;
    if (mode !== 2'b01 || seconds !== 6'd0) begin
      failed++;
      $display("FAIL enter_set_hr: got mode=%0d s=%0d, expected 1 0", mode, seconds);
    end
    press_inc(25);
    tests++;
    if (hours !== 5'd1) begin
      failed++;
      $display("FAIL hour_wrap: got %0d, expected 1", hours);
    end
    press_mode();
    tests++;
    if (mode !== 2'b10) begin
      failed++;
      $display("FAIL enter_set_min: got %0d, expected 2", mode);
    end
    press_inc(60);
    tests++;
    if (minutes !== 6'd1 || hours !== 5'd1) begin
      failed++;
      $display("FAIL min_no_carry: got h=%0d m=%0d, expected 1 1", hours, minutes);
    end
  endtask

  task automatic test_auto_repeat();
    press_inc(59);
    tests++;
    if (minutes !== 6'd0) begin
      failed++;
      $display("FAIL min_to_zero: got %0d, expected 0", minutes);
    end
    set_sq = 1'b1; cyc(2);
    tests++;
    if (blink_min !== 1'b1 || blink_hr !== 1'b0) begin
      failed++;
      $display("FAIL blink_set_min: got bm=%b bh=%b, expected 1 0", blink_min, blink_hr);
    end
    set_sq = 1'b0; cyc(2);
    tests++;
    if (blink_min !== 1'b0) begin
      failed++;
      $display("FAIL blink_low: got %b, expected 0", blink_min);
    end
    btn_inc = 1'b1; cyc(3);
    pulse_set(5);
    tests++;
    if (minutes !== 6'd4) begin
      failed++;
      $display("FAIL auto_repeat: got %0d, expected 4", minutes);
    end
    btn_inc = 1'b0; cyc(2);
    pulse_set(1);
    tests++;
    if (minutes !== 6'd4) begin
      failed++;
      $display("FAIL repeat_release: got %0d, expected 4", minutes);
    end
    press_mode();
    tests++;
    if (mode !== 2'b00) begin
      failed++;
      $display("FAIL back_to_run: got %0d, expected 0", mode);
    end
  endtask

  task automatic test_midnight();
    int hi0;
    press_mode();
    press_inc(22);
    press_mode();
    press_inc(55);
    press_mode();
    hi0 = tick_hi;
    pulse_sec(58);
    tests++;
    if (hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd58 || mode !== 2'b00) begin
      failed++;
      $display("FAIL preload: got %0d:%0d:%0d mode=%0d, expected 23:59:58 0",
               hours, minutes, seconds, mode);
    end
    pulse_sec(2);
    tests++;
    if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0) begin
      failed++;
      $display("FAIL midnight_wrap: got %0d:%0d:%0d, expected 0:0:0", hours, minutes, seconds);
    end
    tests++;
    if (tick_hi - hi0 != 60) begin
      failed++;
      $display("FAIL midnight_ticks: got %0d, expected 60", tick_hi - hi0);
    end
  endtask

  task automatic test_timeout();
    int hi0;
    hi0 = tick_hi;
    press_mode();
    pulse_sec(29);
    tests++;
    if (mode !== 2'b01) begin
      failed++;
      $display("FAIL timeout_29: got mode=%0d, expected 1", mode);
    end
    tests++;
    if (tick_hi != hi0 || seconds !== 6'd0) begin
      failed++;
      $display("FAIL set_no_tick: got ticks=%0d s=%0d, expected 0 0", tick_hi - hi0, seconds);
    end
    sec_sq = 1'b1; cyc(2);
    tests++;
    if (mode !== 2'b01) begin
      failed++;
      $display("FAIL timeout_edge: got mode=%0d, expected 1", mode);
    end
    cyc(1);
    tests++;
    if (mode !== 2'b00 || seconds !== 6'd0) begin
      failed++;
      $display("FAIL timeout_run: got mode=%0d s=%0d, expected 0 0", mode, seconds);
    end
    sec_sq = 1'b0; cyc(2);

    press_mode();
    pulse_sec(20);
    press_inc(1);
    tests++;
    if (hours !== 5'd1) begin
      failed++;
      $display("FAIL timeout_inc: got hours=%0d, expected 1", hours);
    end
    pulse_sec(29);
    tests++;
    if (mode !== 2'b01) begin
      failed++;
      $display("FAIL timeout_restart: got mode=%0d, expected 1", mode);
    end
    pulse_sec(1);
    tests++;
    if (mode !== 2'b00) begin
      failed++;
      $display("FAIL timeout_after_press: got mode=%0d, expected 0", mode);
    end
  endtask

  task automatic test_collision();
    int hi0;
    pulse_sec(2);
    hi0 = tick_hi;
    sec_sq = 1'b1; btn_mode = 1'b1; cyc(2);
    tests++;
    if (mode !== 2'b01 || seconds !== 6'd0 || tick_hi != hi0) begin
      failed++;
      $display("FAIL mode_vs_sec: got mode=%0d s=%0d ticks=%0d, expected 1 0 0",
               mode, seconds, tick_hi - hi0);
    end
    sec_sq = 1'b0; btn_mode = 1'b0; cyc(2);
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(2);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(2);
    tests++;
    if (mode !== 2'b10 || hours !== 5'd1 || minutes !== 6'd0) begin
      failed++;
      $display("FAIL mode_vs_inc: got mode=%0d h=%0d m=%0d, expected 2 1 0", mode, hours, minutes);
    end
    btn_inc = 1'b1; cyc(3);
    pulse_set(3);
    tests++;
    if (minutes !== 6'd2) begin
      failed++;
      $display("FAIL repeat_before_clr: got %0d, expected 2", minutes);
    end
    set_sq = 1'b1; cyc(1);
    clr = 1'b1; cyc(1);
    tests++;
    if ({hours, minutes, seconds, mode, blink_hr, blink_min, sec_tick} !== 26'd0) begin
      failed++;
      $display("FAIL clr_mid_repeat: got h=%0d m=%0d s=%0d mode=%0d bh=%b bm=%b, expected all 0",
               hours, minutes, seconds, mode, blink_hr, blink_min);
    end
    clr = 1'b0; cyc(4);
    tests++;
    if (minutes !== 6'd0 || mode !== 2'b00 || blink_min !== 1'b0) begin
      failed++;
      $display("FAIL clr_release_held: got m=%0d mode=%0d bm=%b, expected 0 0 0", minutes, mode, blink_min);
    end
    btn_inc = 1'b0; set_sq = 1'b0; cyc(2);
  endtask

  task automatic test_back_to_back();
    int hi0;
    hi0 = tick_hi;
    for (int i = 0; i < 3; i++) begin
      sec_sq = 1'b1; cyc(1); sec_sq = 1'b0; cyc(1);
    end
    cyc(3);
    tests++;
    if (seconds !== 6'd3 || tick_hi - hi0 != 3) begin
      failed++;
      $display("FAIL back_to_back: got s=%0d ticks=%0d, expected 3 3", seconds, tick_hi - hi0);
    end
  endtask

  initial begin
    clr = 1'b1; sec_sq = 1'b0; set_sq = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    test_reset();
    test_run_count();
    test_set_nocarry();
    test_auto_repeat();
    test_midnight();
    test_timeout();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
